// File: rtl/voice_alloc.sv
// Polyphonic voice allocator in front of synth.
// Note-on/off events arrive over a valid/ready handshake. Each event is scanned
// against every voice, one voice per cycle, and then committed. When no voice
// is free, the least-recently-allocated voice is stolen.
module voice_alloc #(
  parameter int NUM_UNITS  = 4,
  parameter int FREQ_WIDTH = 16,
  parameter int AMP_WIDTH  = 16,
  parameter int NOTE_WIDTH = 7
) (
  input  logic                            ctl_clk,
  input  logic                            ctl_rst,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [NOTE_WIDTH-1:0]           ev_note,
  input  logic [FREQ_WIDTH-1:0]           ev_freq,
  input  logic [AMP_WIDTH-1:0]            ev_amp,
  input  logic [1:0]                      ev_wave,
  input  logic                            panic,
  output logic [FREQ_WIDTH*NUM_UNITS-1:0] freq_in,
  output logic [AMP_WIDTH*NUM_UNITS-1:0]  amp_in,
  output logic [2*NUM_UNITS-1:0]          wave_type,
  output logic [NUM_UNITS-1:0]            voice_active,
  output logic                            steal
);

  // Voice indices and LRU ranks share one width.
  localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_UNITS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t state;
  logic [IW-1:0] idx;

  // Latched event.
  logic                  on_q;
  logic [NOTE_WIDTH-1:0] tag_q;
  logic [FREQ_WIDTH-1:0] lfreq_q;
  logic [AMP_WIDTH-1:0]  lamp_q;
  logic [1:0]            lwave_q;

  // Scan results.
  logic          match_found;
  logic          free_found;
  logic [IW-1:0] match_idx;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] oldest_idx;

  // Per-voice state.
  logic                  active_q [NUM_UNITS];
  logic [NOTE_WIDTH-1:0] note_q   [NUM_UNITS];
  logic [FREQ_WIDTH-1:0] freq_q   [NUM_UNITS];
  logic [AMP_WIDTH-1:0]  amp_q    [NUM_UNITS];
  logic [1:0]            wave_q   [NUM_UNITS];
  logic [IW-1:0]         rank_q   [NUM_UNITS];

  // Note-on target selection.
  logic [IW-1:0] target;
  logic          take_steal;

  // panic blocks acceptance even in IDLE.
  assign ev_ready = (state == IDLE) && !panic;

  // Choose retrigger, then free voice, then the oldest voice.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    target     = oldest_idx;
    take_steal = 1'b0;
    if (match_found) begin
      target = match_idx;
    end else if (free_found) begin
      target = free_idx;
    end else begin
      take_steal = 1'b1;
    end
  end

  // Handshake FSM: accept, scan one voice per cycle, commit.
  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state       <= IDLE;
      idx         <= '0;
      on_q        <= 1'b0;
      tag_q       <= '0;
      lfreq_q     <= '0;
      lamp_q      <= '0;
      lwave_q     <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      oldest_idx  <= '0;
    end else if (panic) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (ev_valid && ev_ready) begin
            on_q        <= ev_on;
            tag_q       <= ev_note;
            lfreq_q     <= ev_freq;
            lamp_q      <= ev_amp;
            lwave_q     <= ev_wave;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            oldest_idx  <= '0;
            idx         <= '0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (active_q[idx] && (note_q[idx] == tag_q) && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!active_q[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          if (rank_q[idx] == LAST) begin
            oldest_idx <= idx;
          end
          if (idx == LAST) begin
            state <= COMMIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Voice state: committed on COMMIT, cleared by panic.
  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      steal <= 1'b0;
      // NOTE: the voice arrays are a handful of flops, not RAM, so they take reset.
      for (int i = 0; i < NUM_UNITS; i++) begin
        active_q[i] <= 1'b0;
        note_q[i]   <= '0;
        freq_q[i]   <= '0;
        amp_q[i]    <= '0;
        wave_q[i]   <= '0;
        rank_q[i]   <= IW'(i);
      end
    end else begin
      steal <= 1'b0;
      if (panic) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
          active_q[i] <= 1'b0;
          amp_q[i]    <= '0;
        end
      end else if (state == COMMIT) begin
        if (on_q) begin
          steal <= take_steal;
          for (int i = 0; i < NUM_UNITS; i++) begin
            if (IW'(i) == target) begin
              active_q[i] <= 1'b1;
              note_q[i]   <= tag_q;
              freq_q[i]   <= lfreq_q;
              amp_q[i]    <= lamp_q;
              wave_q[i]   <= lwave_q;
              rank_q[i]   <= '0;
            end else if (rank_q[i] < rank_q[target]) begin
              rank_q[i] <= rank_q[i] + 1'b1;
            end
          end
        end else if (match_found) begin
          active_q[match_idx] <= 1'b0;
          amp_q[match_idx]    <= '0;
        end
      end
    end
  end

  // Pack per-voice registers onto the synth buses.
  always_comb begin
    freq_in      = '0;
    amp_in       = '0;
    wave_type    = '0;
    voice_active = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      freq_in[FREQ_WIDTH*i +: FREQ_WIDTH] = freq_q[i];
      amp_in[AMP_WIDTH*i +: AMP_WIDTH]    = amp_q[i];
      wave_type[2*i +: 2]                 = wave_q[i];
      voice_active[i]                     = active_q[i];
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: directed scenarios plus random traffic,
// compared every cycle against a queue-based LRU model.
module tb_voice_alloc;

  localparam int N  = 4;
  localparam int FW = 16;
  localparam int AW = 16;
  localparam int NW = 7;

  logic            ctl_clk = 1'b0;
  logic            ctl_rst = 1'b0;
  logic            ev_valid = 1'b0;
  logic            ev_ready;
  logic            ev_on = 1'b0;
  logic [NW-1:0]   ev_note = '0;
  logic [FW-1:0]   ev_freq = '0;
  logic [AW-1:0]   ev_amp = '0;
  logic [1:0]      ev_wave = '0;
  logic            panic = 1'b0;
  logic [FW*N-1:0] freq_in;
  logic [AW*N-1:0] amp_in;
  logic [2*N-1:0]  wave_type;
  logic [N-1:0]    voice_active;
  logic            steal;

  int total = 0;
  int bad   = 0;

  voice_alloc #(.NUM_UNITS(N), .FREQ_WIDTH(FW), .AMP_WIDTH(AW), .NOTE_WIDTH(NW)) dut (
    .ctl_clk(ctl_clk), .ctl_rst(ctl_rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_freq(ev_freq), .ev_amp(ev_amp),
    .ev_wave(ev_wave), .panic(panic), .freq_in(freq_in), .amp_in(amp_in),
    .wave_type(wave_type), .voice_active(voice_active), .steal(steal)
  );

  always #5 ctl_clk = ~ctl_clk;

  // ---------------- behavioural model ----------------
  logic [FW-1:0] m_freq [N];
  logic [AW-1:0] m_amp  [N];
  logic [1:0]    m_wave [N];
  logic [NW-1:0] m_note [N];
  bit            m_active [N];
  int            m_lru [$];   // front = most recently allocated
  int            m_busy;      // cycles until the accepted event commits
  bit            m_steal;
  bit            p_on;
  logic [NW-1:0] p_tag;
  logic [FW-1:0] p_freq;
  logic [AW-1:0] p_amp;
  logic [1:0]    p_wave;

  function automatic void model_reset();
    m_lru = {};
    for (int i = 0; i < N; i++) begin
      m_freq[i] = '0; m_amp[i] = '0; m_wave[i] = '0; m_note[i] = '0;
      m_active[i] = 0;
      m_lru.push_back(i);
    end
    m_busy = 0;
    m_steal = 0;
  endfunction

  function automatic void model_commit();
    int match = -1;
    int free  = -1;
    int tgt;
    for (int i = 0; i < N; i++) begin
      if (m_active[i] && m_note[i] == p_tag && match < 0) match = i;
      if (!m_active[i] && free < 0) free = i;
    end
    if (p_on) begin
      if (match >= 0) tgt = match;
      else if (free >= 0) tgt = free;
      else begin
        tgt = m_lru[$];
        m_steal = 1;
      end
      m_freq[tgt] = p_freq; m_amp[tgt] = p_amp; m_wave[tgt] = p_wave;
      m_note[tgt] = p_tag;  m_active[tgt] = 1;
      for (int j = 0; j < m_lru.size(); j++) begin
        if (m_lru[j] == tgt) begin
          m_lru.delete(j);
          break;
        end
      end
      m_lru.push_front(tgt);
    end else if (match >= 0) begin
      m_amp[match] = '0;
      m_active[match] = 0;
    end
  endfunction

  // One clock edge of the model, using the inputs presented at that edge.
  function automatic void model_edge();
    m_steal = 0;
    if (panic) begin
      for (int i = 0; i < N; i++) begin
        m_active[i] = 0;
        m_amp[i] = '0;
      end
      m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) model_commit();
    end else if (ev_valid) begin
      p_on = ev_on; p_tag = ev_note; p_freq = ev_freq; p_amp = ev_amp; p_wave = ev_wave;
      m_busy = N + 1;
    end
  endfunction

  function automatic logic [63:0] exp_freq();
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[FW*i +: FW] = m_freq[i];
    return v;
  endfunction

  function automatic logic [63:0] exp_amp();
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[AW*i +: AW] = m_amp[i];
    return v;
  endfunction

  function automatic logic [63:0] exp_wave();
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[2*i +: 2] = m_wave[i];
    return v;
  endfunction

  function automatic logic [63:0] exp_active();
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_active[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  bit chk_en = 0;
  always @(negedge ctl_clk) begin
    if (chk_en) begin
      check("freq_in", 64'(freq_in), exp_freq());
      check("amp_in", 64'(amp_in), exp_amp());
      check("wave_type", 64'(wave_type), exp_wave());
      check("voice_active", 64'(voice_active), exp_active());
      check("steal", 64'(steal), 64'(m_steal));
      check("ev_ready", 64'(ev_ready), 64'((m_busy == 0) && !panic));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge ctl_clk);
    if (ctl_rst) model_edge();
    #1;
  endtask

  task automatic send(input bit on, input logic [NW-1:0] note, input logic [FW-1:0] f,
                      input logic [AW-1:0] a, input logic [1:0] w);
    int budget = 50;
    ev_valid = 1'b1; ev_on = on; ev_note = note; ev_freq = f; ev_amp = a; ev_wave = w;
    while (!(m_busy == 0 && !panic) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      total++; bad++;
      $display("FAIL send_timeout: event not accepted within budget");
    end
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 50;
    while (m_busy != 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      total++; bad++;
      $display("FAIL idle_timeout: commit not reached within budget");
    end
  endtask

  task automatic do_reset();
    #2;
    ctl_rst = 1'b0;
    model_reset();
    tick();
    tick();
    ctl_rst = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cnt;
    model_reset();
    tick();
    tick();
    chk_en = 1;
    ctl_rst = 1'b1;
    tick();

    // Reset defaults.
    check("rst_freq", 64'(freq_in), 64'h0);
    check("rst_active", 64'(voice_active), 64'h0);
    check("rst_ready", 64'(ev_ready), 64'h1);
    tick();
    check("rst_idle_amp", 64'(amp_in), 64'h0);

    // Basic allocation.
    send(1, 60, 440, 16'h100, 1);
    cnt = 0;
    while (ev_ready == 1'b0 && cnt < 20) begin
      cnt++;
      tick();
    end
    check("ready_low_cycles", 64'(cnt), 64'd5);
    check("v0_freq", 64'(freq_in[15:0]), 64'd440);
    check("v0_amp", 64'(amp_in[15:0]), 64'h100);
    check("v0_wave", 64'(wave_type[1:0]), 64'd1);
    check("active_0001", 64'(voice_active), 64'b0001);

    send(1, 64, 500, 16'h200, 2);
    wait_idle();
    check("v1_freq", 64'(freq_in[31:16]), 64'd500);
    check("active_0011", 64'(voice_active), 64'b0011);

    // Retrigger and note-off.
    send(1, 60, 440, 16'h80, 1);
    wait_idle();
    check("retrig_amp", 64'(amp_in[15:0]), 64'h80);
    check("retrig_steal", 64'(steal), 64'h0);
    check("retrig_active", 64'(voice_active), 64'b0011);

    send(0, 60, 0, 0, 0);
    wait_idle();
    check("off_amp", 64'(amp_in[15:0]), 64'h0);
    check("off_freq", 64'(freq_in[15:0]), 64'd440);
    check("off_active", 64'(voice_active), 64'b0010);

    send(0, 99, 16'hffff, 16'hffff, 3);
    wait_idle();
    check("miss_active", 64'(voice_active), 64'b0010);
    check("miss_amp", 64'(amp_in), 64'h0000_0000_0200_0000);

    // Steal from a clean state.
    do_reset();
    for (int n = 10; n < 14; n++) begin
      send(1, NW'(n), FW'(1000 + n), 16'h10, 0);
      wait_idle();
    end
    check("full_active", 64'(voice_active), 64'b1111);
    send(1, 14, 2014, 16'h20, 3);
    wait_idle();
    check("steal_pulse", 64'(steal), 64'h1);
    check("steal_v0_freq", 64'(freq_in[15:0]), 64'd2014);
    tick();
    check("steal_one_cycle", 64'(steal), 64'h0);
    send(1, 15, 2015, 16'h30, 2);
    wait_idle();
    check("steal_v1_freq", 64'(freq_in[31:16]), 64'd2015);
    check("steal_v1_pulse", 64'(steal), 64'h1);

    // Panic during SCAN.
    send(1, 20, 3000, 16'h40, 1);
    tick();
    tick();
    panic = 1'b1;
    tick();
    panic = 1'b0;
    check("panic_active", 64'(voice_active), 64'h0);
    check("panic_amp", 64'(amp_in), 64'h0);
    check("panic_freq_kept", 64'(freq_in[15:0]), 64'd2014);
    tick();
    check("panic_ready", 64'(ev_ready), 64'h1);

    // panic together with ev_valid in IDLE.
    panic = 1'b1;
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 30; ev_freq = 123; ev_amp = 16'h55;
    tick();
    panic = 1'b0;
    ev_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("panic_valid_dropped", 64'(voice_active), 64'h0);

    // Asynchronous reset mid-SCAN.
    send(1, 40, 4040, 16'h44, 2);
    tick();
    #2;
    ctl_rst = 1'b0;
    model_reset();
    #1;
    check("async_rst_freq", 64'(freq_in), 64'h0);
    check("async_rst_wave", 64'(wave_type), 64'h0);
    tick();
    ctl_rst = 1'b1;
    send(1, 41, 4141, 16'h41, 1);
    wait_idle();
    check("post_rst_active", 64'(voice_active), 64'b0001);
    check("post_rst_freq", 64'(freq_in[15:0]), 64'd4141);

    // Random traffic against the model.
    for (int e = 0; e < 400; e++) begin
      int gap;
      send(1'($urandom_range(0, 2) != 0), NW'($urandom_range(0, 7)),
           FW'($urandom), AW'($urandom), 2'($urandom));
      gap = $urandom_range(0, 7);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 39) == 0) panic = 1'b1;
        tick();
        panic = 1'b0;
      end
    end
    wait_idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_alloc.md
# voice_alloc

Polyphonic voice allocator that sits in front of `synth`. It accepts note-on and note-off events over a valid/ready handshake and assigns each event to one of NUM_UNITS oscillator units. It drives the packed `freq_in`, `amp_in` and `wave_type` buses of `synth` directly. When every unit is busy it steals the least-recently-allocated voice.

## Interface
- NUM_UNITS, 4: number of voices; must match `synth`.
- FREQ_WIDTH, 16: per-voice frequency width.
- AMP_WIDTH, 16: per-voice amplitude width.
- NOTE_WIDTH, 7: note-number tag width, used for matching only.

- ctl_clk  in  1  control clock; the only clock.
- ctl_rst  in  1  asynchronous, active-low reset.
- ev_valid  in  1  an event is presented.
- ev_ready  out  1  the block can accept an event.
- ev_on  in  1  event type: 1 = note-on, 0 = note-off.
- ev_note  in  NOTE_WIDTH  note tag.
- ev_freq  in  FREQ_WIDTH  frequency for note-on.
- ev_amp  in  AMP_WIDTH  amplitude for note-on.
- ev_wave  in  2  waveform select for note-on.
- panic  in  1  synchronous all-voices-off.
- freq_in  out  FREQ_WIDTH*NUM_UNITS  packed; voice i occupies [FREQ_WIDTH*(i+1)-1 : FREQ_WIDTH*i].
- amp_in  out  AMP_WIDTH*NUM_UNITS  packed, same layout.
- wave_type  out  2*NUM_UNITS  packed, same layout.
- voice_active  out  NUM_UNITS  bit i set while voice i holds a note.
- steal  out  1  one-cycle pulse when a note-on evicted an active voice.

## Operation
- **Per-voice state:** active, note tag, freq, amp, wave, and an LRU rank.
- **Ranks:** ranks always form a permutation of 0..NUM_UNITS-1. Rank 0 is the most recently allocated voice.
- **FSM states:** IDLE, SCAN, COMMIT.
  - IDLE: `ev_ready = 1` when `panic = 0`. On `ev_valid & ev_ready`, latch all ev_* fields, clear the scan results, set idx = 0, and go to SCAN.
  - SCAN: examine voice idx on each cycle, with idx running 0 to NUM_UNITS-1. Record three results:
    - match: the lowest idx that is active and whose tag equals ev_note.
    - free: the lowest idx that is inactive.
    - oldest: the idx whose rank equals NUM_UNITS-1.
  - After idx = NUM_UNITS-1, go to COMMIT.
  - COMMIT: apply the latched event (rules below), then go to IDLE.
- **Note-on target:** the matched voice if there is a match (retrigger). Otherwise the free voice. Otherwise the oldest voice, and `steal` pulses for that cycle.
  - The target's freq, amp, wave and tag are loaded from the latched event, and active is set to 1.
  - Let r be the target's old rank. The target's rank becomes 0, and every voice with rank < r increments.
- **Note-off:** if there is a match, that voice's amp becomes 0 and active is cleared. Its freq, wave and rank are unchanged. If there is no match, the event is dropped silently and no output changes. ev_freq, ev_amp and ev_wave are ignored for note-off.
- **Inactive voices:** they output amp = 0 and keep their last freq and wave.
- **panic = 1, any state:**
  - On the next edge, all active bits and amp fields clear.
  - Any in-flight event is discarded and the FSM returns to IDLE.
  - freq, wave and ranks are untouched.
  - panic has priority over a simultaneous `ev_valid`: ev_ready is 0, so the event is not accepted.
- **Arithmetic:** rank counters are clog2(NUM_UNITS) bits wide and never wrap, because only ranks below r increment. The event fields are written to the outputs unmodified.

## Timing
- **Reset (ctl_rst = 0):** asynchronous.
  - freq_in, amp_in, wave_type, voice_active = 0; steal = 0.
  - FSM = IDLE, so ev_ready = 1 during and after reset (when panic = 0).
  - rank[i] = i, so voice NUM_UNITS-1 is the initial steal victim.
- **Reset mid-operation:** the event is lost and all state returns to the reset values immediately.
- **Handshake:** an event is accepted on the edge where ev_valid and ev_ready are both high. The producer must hold the fields stable until acceptance.
- **Latency:** with acceptance on edge k:
  - SCAN occupies edges k+1 to k+NUM_UNITS.
  - Outputs, voice_active and steal update on edge k+NUM_UNITS+1.
  - ev_ready is 0 from k+1 through k+NUM_UNITS+1 and returns to 1 after that edge, giving one accepted event per NUM_UNITS+2 cycles.
- **steal:** registered; high exactly for the cycle following the COMMIT edge.
- **Outputs:** all registered; they are stable between COMMIT and panic edges.

## Test plan
- **Reset defaults:** release reset. All outputs are 0, ev_ready = 1, and panic = 0 gives no change.
- **Basic allocation:**
  - Note-on note = 60, freq = 440, amp = 0x100, wave = 1 → voice 0 gets freq 440, amp 0x100, wave 1. voice_active = 0001, ready low for 5 cycles.
  - A second note-on, note = 64 → voice 1; voice_active = 0011.
- **Retrigger and note-off:**
  - Note-on note = 60 again with amp = 0x80 → voice 0 reloads with amp = 0x80, no steal, voice_active unchanged.
  - Note-off note = 60 → amp[0] = 0, freq[0] stays 440, voice_active bit 0 clears.
  - Note-off note = 99 → no output change.
- **Steal:**
  - Note-on notes 10, 11, 12, 13 fill voices 0 to 3.
  - Note-on note 14 → voice 0 (rank 3) is overwritten and steal pulses for one cycle.
  - Note-on note 15 → voice 1 is stolen.
- **Panic:**
  - Assert panic during SCAN of a note-on → the event is discarded, all amps go to 0, voice_active = 0, and ev_ready = 1 the cycle after panic drops.
  - panic together with ev_valid in IDLE → the event is not accepted.
- **Asynchronous reset mid-SCAN:** assert ctl_rst = 0 mid-SCAN → outputs clear without waiting for a clock edge, and the next event allocates voice 0.
